// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single data_memory port: port A (MEM stage) has priority,
// port B (loader/debug) is guaranteed service by a starvation counter.
module dmem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        we_a,
    input  logic        we_b,
    input  logic [31:0] addr_a,
    input  logic [31:0] addr_b,
    input  logic [31:0] wdata_a,
    input  logic [31:0] wdata_b,
    input  logic [1:0]  size_a,
    input  logic [1:0]  size_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        err_a,
    output logic        err_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [1:0]  mem_size_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    input  logic [31:0] mem_rdata_in
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_ACK   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Unmapped regions and sub-word reads are rejected without touching memory.
    function automatic logic is_bad(input logic we, input logic [31:0] addr, input logic [1:0] size);
        logic mapped;
        mapped = (addr[31:16] == 16'h1000) || (addr[31:16] == 16'h7fff) || (addr[31:16] == 16'hffff);
        return !mapped || (!we && (size != 2'b11));
    endfunction

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic             bad_q, bad_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [1:0]       size_q, size_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             mem_re_q, mem_re_d;
    logic             mem_we_q, mem_we_d;
    logic             ack_a_q, ack_a_d, err_a_q, err_a_d;
    logic             ack_b_q, ack_b_d, err_b_q, err_b_d;
    logic [31:0]      rdata_a_q, rdata_a_d;
    logic [31:0]      rdata_b_q, rdata_b_d;
    logic             pick_b_s;
    logic [31:0]      rd_val_s;

    // Next-state, grant selection and response generation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        bad_d     = bad_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        wait_d    = wait_q;
        mem_re_d  = 1'b0;
        mem_we_d  = 1'b0;
        ack_a_d   = 1'b0;
        err_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        err_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        pick_b_s  = 1'b0;
        rd_val_s  = 32'h0000_0000;
        case (state_q)
            S_IDLE: begin
                if (req_a || req_b) begin
                    pick_b_s = req_b && (!req_a || (wait_q == LIMIT));
                    owner_d  = pick_b_s;
                    we_d     = pick_b_s ? we_b    : we_a;
                    addr_d   = pick_b_s ? addr_b  : addr_a;
                    wdata_d  = pick_b_s ? wdata_b : wdata_a;
                    size_d   = pick_b_s ? size_b  : size_a;
                    bad_d    = is_bad(we_d, addr_d, size_d);
                    mem_re_d = !bad_d && !we_d;
                    mem_we_d = !bad_d && we_d;
                    if (pick_b_s) begin
                        wait_d = {CNT_W{1'b0}};
                    end else if (req_b && (wait_q != LIMIT)) begin
                        wait_d = wait_q + CNT_W'(1);
                    end else begin
                        wait_d = wait_q;
                    end
                    state_d = S_SERVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SERVE: begin
                rd_val_s = (!we_q && !bad_q) ? mem_rdata_in : 32'h0000_0000;
                if (owner_q) begin
                    rdata_b_d = rd_val_s;
                    ack_b_d   = 1'b1;
                    err_b_d   = bad_q;
                end else begin
                    rdata_a_d = rd_val_s;
                    ack_a_d   = 1'b1;
                    err_a_d   = bad_q;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the strobes without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            bad_q     <= 1'b0;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            size_q    <= 2'b00;
            wait_q    <= {CNT_W{1'b0}};
            mem_re_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            ack_a_q   <= 1'b0;
            err_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            err_b_q   <= 1'b0;
            rdata_a_q <= 32'h0000_0000;
            rdata_b_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            bad_q     <= bad_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            wait_q    <= wait_d;
            mem_re_q  <= mem_re_d;
            mem_we_q  <= mem_we_d;
            ack_a_q   <= ack_a_d;
            err_a_q   <= err_a_d;
            ack_b_q   <= ack_b_d;
            err_b_q   <= err_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign ack_a         = ack_a_q;
    assign ack_b         = ack_b_q;
    assign err_a         = err_a_q;
    assign err_b         = err_b_q;
    assign rdata_a       = rdata_a_q;
    assign rdata_b       = rdata_b_q;
    assign mem_addr_out  = addr_q;
    assign mem_wdata_out = wdata_q;
    assign mem_size_out  = size_q;
    assign mem_re_out    = mem_re_q;
    assign mem_we_out    = mem_we_q;

endmodule
